// File: rtl/blink_monitor_pkg.sv
// rtl/blink_monitor_pkg.sv - shared FSM state type and default parameters for blink_monitor
package blink_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

  localparam int DEF_CNT_W         = 24;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_TIMEOUT       = 2**24 - 1;
  localparam int DEF_FILTER_CYCLES = 4;

endpackage

// File: rtl/blink_sync_edge.sv
// rtl/blink_sync_edge.sv - input synchronizer, optional glitch filter, registered level and edge pulses
// Glitch filter enabled by defining BLINK_MONITOR_GLITCH_FILTER_EN.
module blink_sync_edge
  import blink_monitor_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic CLK,
  input  logic RST,
  input  logic led_in,
  output logic level,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : g_bad_params
    $error("blink_sync_edge: SYNC_STAGES must be >= 2 and FILTER_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic                   level_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], led_in};
  end

`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  logic [FW-1:0] stable_cnt;

  // Counts consecutive samples disagreeing with the accepted level; any agreeing sample restarts it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      level_q    <= 1'b0;
      stable_cnt <= '0;
    end else if (sync_q[SYNC_STAGES-1] == level_q) begin
      stable_cnt <= '0;
    end else if (stable_cnt == FW'(FILTER_CYCLES - 1)) begin
      level_q    <= sync_q[SYNC_STAGES-1];
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end
`else
  assign level_q = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) level_d <= 1'b0;
    else     level_d <= level_q;
  end

  assign level = level_q;
  assign rise  = level_q & ~level_d;
  assign fall  = ~level_q & level_d;

endmodule

// File: rtl/blink_monitor.sv
// rtl/blink_monitor.sv - measures high/low durations of a blinking input and streams {high, low} records
// Optional glitch filter in blink_sync_edge selected by BLINK_MONITOR_GLITCH_FILTER_EN.
module blink_monitor
  import blink_monitor_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int TIMEOUT       = DEF_TIMEOUT,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             led_in,
  output logic             level,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_high,
  output logic [CNT_W-1:0] meas_low,
  output logic             sat,
  output logic             overrun,
  output logic             stuck
);

  if (TIMEOUT < 1 || TIMEOUT > (2**CNT_W) - 1) begin : g_bad_timeout
    $error("blink_monitor: TIMEOUT must lie in 1 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

  state_t           state;
  logic             rise, fall, edge_seen;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_hold;
  logic             high_sat;
  logic             cnt_sat;
  logic             emit, blocked, xfer;

  blink_sync_edge #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_sync_edge (
    .CLK   (CLK),
    .RST   (RST),
    .led_in(led_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign edge_seen = rise | fall;
  assign cnt_sat   = (cnt == CNT_MAX);
  assign emit      = (state == MEAS_LOW) && rise;
  assign blocked   = meas_valid && !meas_ready;
  assign xfer      = meas_valid && meas_ready;

  // During an edge cycle cnt holds the full length of the interval that just ended.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      high_hold  <= '0;
      high_sat   <= 1'b0;
      meas_valid <= 1'b0;
      meas_high  <= '0;
      meas_low   <= '0;
      sat        <= 1'b0;
      overrun    <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      if (edge_seen)     cnt <= CNT_W'(1);
      else if (!cnt_sat) cnt <= cnt + 1'b1;

      if (edge_seen)              stuck <= 1'b0;
      else if (cnt == TIMEOUT_V)  stuck <= 1'b1;

      case (state)
        IDLE:      if (rise) state <= MEAS_HIGH;
        MEAS_HIGH: if (fall) begin
          state     <= MEAS_LOW;
          high_hold <= cnt;
          high_sat  <= cnt_sat;
        end
        MEAS_LOW:  if (rise) state <= MEAS_HIGH;
        default:   state <= IDLE;
      endcase

      if (emit && !blocked) begin
        meas_valid <= 1'b1;
        meas_high  <= high_hold;
        meas_low   <= cnt;
        sat        <= high_sat | cnt_sat;
      end else if (xfer) begin
        meas_valid <= 1'b0;
      end

      if (emit && blocked) overrun <= 1'b1;
      else if (xfer)       overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blink_monitor.sv
// tb/tb_blink_monitor.sv - randomized and directed bench for blink_monitor with a behavioural model
// Honours BLINK_MONITOR_GLITCH_FILTER_EN in the model and in the glitch expectations.
module tb_blink_monitor;

  localparam int CNT_W         = 6;
  localparam int SYNC_STAGES   = 2;
  localparam int TIMEOUT       = 50;
  localparam int FILTER_CYCLES = 4;
  localparam int MAXV          = (1 << CNT_W) - 1;
  localparam int HN            = SYNC_STAGES + FILTER_CYCLES;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             led_in = 1'b0;
  logic             meas_ready = 1'b0;
  logic             level, meas_valid, sat, overrun, stuck;
  logic [CNT_W-1:0] meas_high, meas_low;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  blink_monitor #(
    .CNT_W        (CNT_W),
    .SYNC_STAGES  (SYNC_STAGES),
    .TIMEOUT      (TIMEOUT),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .led_in    (led_in),
    .level     (level),
    .meas_valid(meas_valid),
    .meas_ready(meas_ready),
    .meas_high (meas_high),
    .meas_low  (meas_low),
    .sat       (sat),
    .overrun   (overrun),
    .stuck     (stuck)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int clip(input int a);
    return (a > MAXV) ? MAXV : a;
  endfunction

  // Model: led samples history, run age, period phase (0 none, 1 high seen, 2 high measured).
  bit hist [HN];
  bit m_level, m_lvl_d, cur, edge_seen, all_diff, blocked, xfer, emit;
  int age, phase, hi_hold, e_low;
  bit hi_sat, e_sat;
  bit m_valid, m_sat, m_overrun, m_stuck;
  int m_high, m_low;

  always @(posedge CLK) begin
    if (RST) begin
      foreach (hist[i]) hist[i] = 1'b0;
      m_level = 0; m_lvl_d = 0; age = 0; phase = 0; hi_hold = 0; hi_sat = 0;
      m_valid = 0; m_high = 0; m_low = 0; m_sat = 0; m_overrun = 0; m_stuck = 0;
    end else begin
      cur       = m_level;
      edge_seen = (cur != m_lvl_d);
      emit      = 0;
      if (edge_seen && cur) begin
        if (phase == 2) begin
          emit  = 1;
          e_low = clip(age);
          e_sat = hi_sat || (age >= MAXV);
        end
        phase = 1;
      end else if (edge_seen && !cur && phase == 1) begin
        hi_hold = clip(age);
        hi_sat  = (age >= MAXV);
        phase   = 2;
      end
      m_stuck = !edge_seen && (age >= TIMEOUT);
      blocked = m_valid && !meas_ready;
      xfer    = m_valid && meas_ready;
      if (emit) begin
        if (blocked) m_overrun = 1;
        else begin
          m_valid = 1; m_high = hi_hold; m_low = e_low; m_sat = e_sat;
          if (xfer) m_overrun = 0;
        end
      end else if (xfer) begin
        m_valid = 0; m_overrun = 0;
      end
      age = edge_seen ? 1 : age + 1;
      m_lvl_d = cur;
      for (int i = HN - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = led_in;
`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
      all_diff = 1;
      for (int i = SYNC_STAGES; i < HN; i++) if (hist[i] == m_level) all_diff = 0;
      if (all_diff) m_level = !m_level;
`else
      m_level = hist[SYNC_STAGES-1];
`endif
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      chk("level", level, m_level);
      chk("meas_valid", meas_valid, m_valid);
      if (m_valid) begin
        chk("meas_high", meas_high, m_high);
        chk("meas_low", meas_low, m_low);
        chk("sat", sat, m_sat);
      end
      chk("overrun", overrun, m_overrun);
      chk("stuck", stuck, m_stuck);
    end
  end

  typedef struct { int h; int l; int s; } rec_t;
  rec_t log_q[$];
  int   vcount = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      if (meas_valid) vcount++;
      if (meas_valid && meas_ready) log_q.push_back('{int'(meas_high), int'(meas_low), int'(sat)});
    end
  end

  task automatic drive(input bit v, input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      led_in = v;
      if (rnd) meas_ready = ($urandom_range(0, 3) != 0);
      @(posedge CLK); #1;
    end
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b1;
    led_in = 1'b0;
    @(negedge CLK);
    chk("rst_valid", meas_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_flags", {sat, overrun, stuck}, 0);
    chk("rst_fields", {meas_high, meas_low}, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    log_q.delete();
    vcount = 0;
  endtask

  task automatic chk_rec(input string name, input int idx, input int h, input int l, input int s);
    if (log_q.size() <= idx) chk({name, "_present"}, log_q.size(), idx + 1);
    else begin
      chk({name, "_high"}, log_q[idx].h, h);
      chk({name, "_low"}, log_q[idx].l, l);
      chk({name, "_sat"}, log_q[idx].s, s);
    end
  endtask

  initial begin
    meas_ready = 1'b1;
    do_reset();

    // idle low: no record, stuck after TIMEOUT cycles without an edge
    drive(0, 30, 0);
    chk("idle_stuck_early", stuck, 0);
    drive(0, 70, 0);
    chk("idle_stuck_late", stuck, 1);
    chk("idle_no_valid", vcount, 0);

    // single period 10/5
    do_reset();
    meas_ready = 1'b1;
    drive(0, 5, 0); drive(1, 10, 0); drive(0, 5, 0); drive(1, 10, 0); drive(0, 5, 0);
    chk("p1_count", log_q.size(), 1);
    chk_rec("p1", 0, 10, 5, 0);
    chk("p1_valid_cycles", vcount, 1);

    // backpressure: second record dropped, overrun set then cleared by transfer
    do_reset();
    meas_ready = 1'b0;
    drive(0, 5, 0); drive(1, 8, 0); drive(0, 8, 0); drive(1, 6, 0); drive(0, 4, 0);
    drive(1, 3, 0); drive(0, 3, 0);
    chk("bp_valid", meas_valid, 1);
    chk("bp_high", meas_high, 8);
    chk("bp_low", meas_low, 8);
    chk("bp_overrun", overrun, 1);
    meas_ready = 1'b1;
    drive(0, 3, 0);
    chk("bp_valid_after", meas_valid, 0);
    chk("bp_overrun_after", overrun, 0);
    chk_rec("bp", 0, 8, 8, 0);

    // stuck while high, cleared by the falling edge
    do_reset();
    drive(0, 5, 0); drive(1, 45, 0);
    chk("stuck_before", stuck, 0);
    drive(1, 15, 0);
    chk("stuck_set", stuck, 1);
    drive(0, 4, 0);
    chk("stuck_cleared", stuck, 0);

    // saturation of the high field
    do_reset();
    drive(0, 5, 0); drive(1, 70, 0); drive(0, 3, 0); drive(1, 5, 0); drive(0, 2, 0);
    chk_rec("satrec", 0, MAXV, 3, 1);

    // short pulse during the low phase
    do_reset();
    drive(0, 5, 0); drive(1, 5, 0); drive(0, 10, 0); drive(1, 2, 0); drive(0, 10, 0);
    drive(1, 5, 0); drive(0, 3, 0);
`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
    chk("glitch_count", log_q.size(), 1);
    chk_rec("glitch", 0, 5, 22, 0);
`else
    chk("glitch_count", log_q.size(), 2);
    chk_rec("glitch_a", 0, 5, 10, 0);
    chk_rec("glitch_b", 1, 2, 10, 0);
`endif

    // random runs with random backpressure and a reset in the middle
    do_reset();
    for (int r = 0; r < 160; r++) begin
      if (r == 80) do_reset();
      drive(r[0], ($urandom_range(0, 9) == 0) ? $urandom_range(40, 75) : $urandom_range(1, 12), 1);
    end
    meas_ready = 1'b1;
    drive(0, 10, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
